contrast_value_uart_reporter: RTL and testbench



---
 rtl/contrast_value_uart_reporter_if.sv | 13 +
 rtl/contrast_value_uart_reporter.sv | 210 +++++++++++++++++++++
 tb/tb_contrast_value_uart_reporter.sv | 199 +++++++++++++++++++
 3 files changed

// File: rtl/contrast_value_uart_reporter_if.sv
// Contrast reporter bus: change strobe plus value in, UART line and status out.
interface contrast_value_uart_reporter_if #(
   parameter int VALUE_WIDTH = 10
);
   logic                   value_changed;
   logic [VALUE_WIDTH-1:0] value;
   logic                   tx;
   logic                   busy;
   logic                   pending;

   modport master (output value_changed, value, input tx, busy, pending);
   modport slave  (input value_changed, value, output tx, busy, pending);
endinterface

// File: rtl/contrast_value_uart_reporter.sv
// Debounced contrast value reporter: hold-off, double-dabble, 8N1 line "C=dddd\r\n".
// Optional checksum characters enabled by CONTRAST_REPORT_CHECKSUM_EN.
module contrast_value_uart_reporter #(
   parameter int          CLOCK_FREQUENCY = 16000000,
   parameter int          BAUD_RATE       = 115200,
   parameter int          VALUE_WIDTH     = 10,
   parameter int          HOLDOFF_CYCLES  = 320000,
   parameter logic [7:0]  PREFIX_CHAR     = 8'h43
) (
   input  logic clk,
   input  logic reset,
   contrast_value_uart_reporter_if.slave rpt
);

   localparam int BIT_CYCLES_RAW = CLOCK_FREQUENCY / BAUD_RATE;
   localparam int BIT_CYCLES     = (BIT_CYCLES_RAW < 2) ? 2 : BIT_CYCLES_RAW;
`ifdef CONTRAST_REPORT_CHECKSUM_EN
   localparam int NUM_CHARS      = 10;
`else
   localparam int NUM_CHARS      = 8;
`endif
   localparam int BW = $clog2(BIT_CYCLES);
   localparam int HW = (HOLDOFF_CYCLES > 1) ? $clog2(HOLDOFF_CYCLES) : 1;
   localparam int CW = (VALUE_WIDTH > 1) ? $clog2(VALUE_WIDTH) : 1;

   localparam logic [BW-1:0] BAUD_LAST = BW'(BIT_CYCLES - 1);
   localparam logic [HW-1:0] HOLD_LAST = HW'(HOLDOFF_CYCLES - 1);
   localparam logic [CW-1:0] CONV_LAST = CW'(VALUE_WIDTH - 1);
   localparam logic [3:0]    CHAR_LAST = 4'(NUM_CHARS - 1);
   localparam logic [3:0]    BIT_LAST  = 4'd9;

   typedef enum logic [1:0] {
      S_IDLE,
      S_HOLDOFF,
      S_CONVERT,
      S_SEND
   } state_t;

   state_t                 state_q, state_d;
   logic [HW-1:0]          hold_q, hold_d;
   logic [CW-1:0]          conv_q, conv_d;
   logic [VALUE_WIDTH-1:0] shadow_q, shadow_d;
   logic [VALUE_WIDTH-1:0] bin_q, bin_d;
   logic [15:0]            bcd_q, bcd_d;
   logic                   pending_q, pending_d;
   logic [BW-1:0]          baud_q, baud_d;
   logic [3:0]             bit_q, bit_d;
   logic [3:0]             char_q, char_d;
   logic                   tx_q, tx_d;

   logic                   vc;
   logic [VALUE_WIDTH-1:0] vin;
   logic [7:0]             char_byte;
   logic [9:0]             char_frame;

   assign vc  = rpt.value_changed;
   assign vin = rpt.value;

   function automatic logic [15:0] dd_adjust(input logic [15:0] b);
      logic [15:0] r;
      r = b;
      for (int unsigned i = 0; i < 4; i++) begin
         if (r[4*i +: 4] >= 4'd5) r[4*i +: 4] = r[4*i +: 4] + 4'd3;
      end
      return r;
   endfunction

`ifdef CONTRAST_REPORT_CHECKSUM_EN
   function automatic logic [7:0] hex_ascii(input logic [3:0] n);
      return (n < 4'd10) ? (8'h30 + {4'h0, n}) : (8'h37 + {4'h0, n});
   endfunction
`endif

   // ---------------- state register ----------------
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q   <= S_IDLE;
         hold_q    <= '0;
         conv_q    <= '0;
         shadow_q  <= '0;
         bin_q     <= '0;
         bcd_q     <= '0;
         pending_q <= 1'b0;
         baud_q    <= '0;
         bit_q     <= '0;
         char_q    <= '0;
         tx_q      <= 1'b1;
      end else begin
         state_q   <= state_d;
         hold_q    <= hold_d;
         conv_q    <= conv_d;
         shadow_q  <= shadow_d;
         bin_q     <= bin_d;
         bcd_q     <= bcd_d;
         pending_q <= pending_d;
         baud_q    <= baud_d;
         bit_q     <= bit_d;
         char_q    <= char_d;
         tx_q      <= tx_d;
      end
   end

   // ---------------- next-state logic ----------------
   always_comb begin
      state_d   = state_q;
      hold_d    = hold_q;
      conv_d    = conv_q;
      shadow_d  = vc ? vin : shadow_q;
      bin_d     = bin_q;
      bcd_d     = bcd_q;
      pending_d = pending_q;
      baud_d    = baud_q;
      bit_d     = bit_q;
      char_d    = char_q;

      unique case (state_q)
         S_IDLE: begin
            if (vc) begin
               state_d = S_HOLDOFF;
               hold_d  = '0;
            end
         end
         S_HOLDOFF: begin
            if (vc) begin
               hold_d = '0;
            end else if (hold_q == HOLD_LAST) begin
               state_d = S_CONVERT;
               conv_d  = '0;
               bin_d   = shadow_q;
               bcd_d   = '0;
            end else begin
               hold_d = hold_q + 1'b1;
            end
         end
         S_CONVERT: begin
            if (vc) pending_d = 1'b1;
            bcd_d  = (dd_adjust(bcd_q) << 1) | 16'(bin_q[VALUE_WIDTH-1]);
            bin_d  = bin_q << 1;
            conv_d = conv_q + 1'b1;
            if (conv_q == CONV_LAST) begin
               state_d = S_SEND;
               baud_d  = '0;
               bit_d   = '0;
               char_d  = '0;
            end
         end
         S_SEND: begin
            if (vc) pending_d = 1'b1;
            if (baud_q != BAUD_LAST) begin
               baud_d = baud_q + 1'b1;
            end else begin
               baud_d = '0;
               if (bit_q != BIT_LAST) begin
                  bit_d = bit_q + 1'b1;
               end else begin
                  bit_d = '0;
                  if (char_q != CHAR_LAST) begin
                     char_d = char_q + 1'b1;
                  end else begin
                     // A strobe in this very cycle counts as pending for the decision.
                     state_d   = (pending_q || vc) ? S_HOLDOFF : S_IDLE;
                     hold_d    = '0;
                     pending_d = 1'b0;
                  end
               end
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   // ---------------- output logic ----------------
   always_comb begin
      logic [7:0] d3, d2, d1, d0;
`ifdef CONTRAST_REPORT_CHECKSUM_EN
      logic [7:0] cks;
`endif
      d3 = {4'h3, bcd_q[15:12]};
      d2 = {4'h3, bcd_q[11:8]};
      d1 = {4'h3, bcd_q[7:4]};
      d0 = {4'h3, bcd_q[3:0]};
`ifdef CONTRAST_REPORT_CHECKSUM_EN
      cks = PREFIX_CHAR ^ 8'h3D ^ d3 ^ d2 ^ d1 ^ d0;
`endif
      case (char_d)
         4'd0:    char_byte = PREFIX_CHAR;
         4'd1:    char_byte = 8'h3D;
         4'd2:    char_byte = d3;
         4'd3:    char_byte = d2;
         4'd4:    char_byte = d1;
         4'd5:    char_byte = d0;
`ifdef CONTRAST_REPORT_CHECKSUM_EN
         4'd6:    char_byte = hex_ascii(cks[7:4]);
         4'd7:    char_byte = hex_ascii(cks[3:0]);
         4'd8:    char_byte = 8'h0D;
`else
         4'd6:    char_byte = 8'h0D;
`endif
         default: char_byte = 8'h0A;
      endcase
      char_frame = {1'b1, char_byte, 1'b0};
      // tx is registered: select the bit the next state will present.
      tx_d = (state_d == S_SEND) ? char_frame[bit_d] : 1'b1;
   end

   assign rpt.tx      = tx_q;
   assign rpt.busy    = (state_q == S_CONVERT) || (state_q == S_SEND);
   assign rpt.pending = pending_q;

endmodule

// File: tb/tb_contrast_value_uart_reporter.sv
// Directed bench for contrast_value_uart_reporter: decodes UART frames and checks timing.
module tb_contrast_value_uart_reporter;

   localparam int BC   = 16;
   localparam int HOLD = 100;
   localparam int VW   = 10;
   localparam int LAT  = HOLD + VW + 1;

   logic clk = 1'b0;
   logic reset;
   int   cyc = 0;
   int   n_tests = 0;
   int   n_fail = 0;

   contrast_value_uart_reporter_if #(.VALUE_WIDTH(VW)) rif ();

   contrast_value_uart_reporter #(
      .CLOCK_FREQUENCY(16000000),
      .BAUD_RATE      (1000000),
      .VALUE_WIDTH    (VW),
      .HOLDOFF_CYCLES (HOLD),
      .PREFIX_CHAR    (8'h43)
   ) dut (
      .clk  (clk),
      .reset(reset),
      .rpt  (rif)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic string line(input string digits, input string cks);
`ifdef CONTRAST_REPORT_CHECKSUM_EN
      return {"C=", digits, cks, "\r\n"};
`else
      return {"C=", digits, "\r\n"};
`endif
   endfunction

   task automatic wait_until(input int t);
      while (cyc < t) @(negedge clk);
   endtask

   task automatic strobe(input logic [VW-1:0] v, output int t);
      rif.value         = v;
      rif.value_changed = 1'b1;
      t = cyc;
      @(negedge clk);
      rif.value_changed = 1'b0;
   endtask

   // Entered at the negedge of the start-bit's first cycle; returns at the last stop cycle.
   task automatic recv_char(output logic [7:0] b, output bit clean);
      logic [9:0] bits;
      bits  = '0;
      clean = 1'b1;
      for (int i = 0; i < 10; i++) begin
         for (int c = 0; c < BC; c++) begin
            if (i != 0 || c != 0) @(negedge clk);
            if (c == 0) bits[i] = rif.tx;
            else if (rif.tx !== bits[i]) clean = 1'b0;
         end
      end
      if (bits[0] !== 1'b0 || bits[9] !== 1'b1) clean = 1'b0;
      b = bits[8:1];
   endtask

   task automatic expect_frame(input string tag, input string exp, input int exp_start,
                               output int end_at);
      bit         found;
      bit         clean;
      int         at;
      logic [7:0] b;
      found = 1'b0;
      at    = 0;
      for (int i = 0; i < LAT + 300 && !found; i++) begin
         @(negedge clk);
         if (rif.tx === 1'b0) begin
            found = 1'b1;
            at    = cyc;
         end
      end
      chk({tag, " start_found"}, 32'(found), 32'd1);
      if (!found) begin
         end_at = cyc;
         return;
      end
      chk({tag, " start_cycle"}, at, exp_start);
      for (int i = 0; i < exp.len(); i++) begin
         if (i != 0) @(negedge clk);
         recv_char(b, clean);
         chk($sformatf("%s char%0d", tag, i), 32'(b), 32'(exp[i]));
         chk($sformatf("%s bits%0d", tag, i), 32'(clean), 32'd1);
      end
      end_at = cyc;
   endtask

   initial begin
      int t, t2, e, lows;
      reset             = 1'b1;
      rif.value_changed = 1'b0;
      rif.value         = '0;
      repeat (3) @(negedge clk);
      chk("reset tx", 32'(rif.tx), 32'd1);
      chk("reset busy", 32'(rif.busy), 32'd0);
      chk("reset pending", 32'(rif.pending), 32'd0);
      reset = 1'b0;
      repeat (2) @(negedge clk);

      // 1: single value, latency and end-of-frame status
      strobe(10'd517, t);
      wait_until(t + HOLD);
      chk("t1 busy holdoff", 32'(rif.busy), 32'd0);
      wait_until(t + HOLD + 5);
      chk("t1 busy convert", 32'(rif.busy), 32'd1);
      expect_frame("t1", line("0517", "7D"), t + LAT, e);
      chk("t1 busy last stop", 32'(rif.busy), 32'd1);
      @(negedge clk);
      chk("t1 busy end", 32'(rif.busy), 32'd0);
      chk("t1 pending end", 32'(rif.pending), 32'd0);
      chk("t1 tx idle", 32'(rif.tx), 32'd1);
      repeat (5) @(negedge clk);

      // 2: boundary values
      strobe(10'd0, t);
      expect_frame("t2a", line("0000", "7E"), t + LAT, e);
      repeat (5) @(negedge clk);
      strobe(10'd1023, t);
      expect_frame("t2b", line("1023", "7E"), t + LAT, e);
      repeat (5) @(negedge clk);

      // 3: burst coalescing
      strobe(10'd10, t);
      wait_until(t + 50);
      strobe(10'd20, t2);
      wait_until(t + 100);
      strobe(10'd30, t2);
      expect_frame("t3", line("0030", "7D"), t2 + LAT, e);
      @(negedge clk);
      lows = 0;
      for (int i = 0; i < LAT + 50; i++) begin
         @(negedge clk);
         if (rif.tx !== 1'b1) lows++;
      end
      chk("t3 single frame", lows, 0);

      // 4: change during third character
      strobe(10'd100, t);
      fork
         begin
            wait_until(t + LAT + 2 * 10 * BC + 10);
            rif.value         = 10'd200;
            rif.value_changed = 1'b1;
            @(negedge clk);
            rif.value_changed = 1'b0;
         end
      join_none
      expect_frame("t4a", line("0100", "7F"), t + LAT, e);
      chk("t4 pending last stop", 32'(rif.pending), 32'd1);
      @(negedge clk);
      chk("t4 pending cleared", 32'(rif.pending), 32'd0);
      chk("t4 busy holdoff", 32'(rif.busy), 32'd0);
      expect_frame("t4b", line("0200", "7C"), e + LAT, e);
      repeat (5) @(negedge clk);

      // 5: reset mid-frame, then a clean frame
      strobe(10'd517, t);
      wait_until(t + LAT + 2 * 10 * BC + 5 * BC + 8);
      reset = 1'b1;
      #1;
      chk("t5 tx on reset", 32'(rif.tx), 32'd1);
      chk("t5 busy on reset", 32'(rif.busy), 32'd0);
      chk("t5 pending on reset", 32'(rif.pending), 32'd0);
      @(negedge clk);
      reset = 1'b0;
      lows = 0;
      for (int i = 0; i < 300; i++) begin
         @(negedge clk);
         if (rif.tx !== 1'b1) lows++;
      end
      chk("t5 no bytes after reset", lows, 0);
      strobe(10'd5, t);
      expect_frame("t5", line("0005", "7B"), t + LAT, e);
      @(negedge clk);
      chk("t5 busy end", 32'(rif.busy), 32'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
